// File: rtl/stalling_data_memory_pkg.sv
// Shared types and defaults for the stalling data memory and its helpers.
package stalling_data_memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_BASE_ADDR  = 1024;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_DATA_WIDTH = 32;

    // Smallest n with 2**n >= v; clog2(1) is 0.
    function automatic int clog2(input int v);
        int n;
        n = 0;
        while ((1 << n) < v) n++;
        return n;
    endfunction

endpackage

// File: rtl/stalling_data_memory_if.sv
// Pipeline-to-memory bus: the MEM stage drives requests, the memory answers with ready.
interface stalling_data_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  ready;
    logic                  addr_err;

    modport master (
        output addr, write_data, mem_read, mem_write,
        input  read_data, ready, addr_err
    );

    modport slave (
        input  addr, write_data, mem_read, mem_write,
        output read_data, ready, addr_err
    );
endinterface

// File: rtl/stalling_data_memory_wait_counter.sv
// Loadable down-counter used to time memory wait states; zero_o flags expiry.
module wait_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_value_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] count_q;

    // Load wins over decrement; the counter parks at zero rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       count_q <= '0;
        else if (load_i)               count_q <= load_value_i;
        else if (dec_i && !zero_o)     count_q <= count_q - W'(1);
    end

    assign zero_o = (count_q == '0);
endmodule

// File: rtl/stalling_data_memory.sv
// Word-addressed data memory with fixed wait states; ready stalls the pipeline until an access completes.
module stalling_data_memory
    import stalling_data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int BASE_ADDR  = DEF_BASE_ADDR,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    stalling_data_memory_if.slave bus
);
    localparam int IW = clog2(DEPTH);
    localparam int CW = clog2(LATENCY) + 1;

    state_t                state_q;
    logic [IW-1:0]         idx_q;
    logic                  in_range_q;
    logic                  is_write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  addr_err_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  req;
    logic [ADDR_WIDTH-1:0] off_d;
    logic [ADDR_WIDTH-1:0] word_d;
    logic                  in_range_d;
    logic                  cnt_load;
    logic                  cnt_zero;

    assign req    = bus.mem_read | bus.mem_write;
    // Subtraction wraps below BASE_ADDR, so the lower bound is checked on the raw address.
    assign off_d      = bus.addr - ADDR_WIDTH'(BASE_ADDR);
    assign word_d     = off_d >> 2;
    assign in_range_d = (bus.addr >= ADDR_WIDTH'(BASE_ADDR)) && (word_d < ADDR_WIDTH'(DEPTH));

    assign cnt_load = (state_q == IDLE) && req;

    wait_counter #(.W(CW)) u_wait (
        .clk          (clk),
        .rst          (rst),
        .load_i       (cnt_load),
        .load_value_i (CW'(LATENCY - 1)),
        .dec_i        (state_q == BUSY),
        .zero_o       (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            in_range_q  <= 1'b0;
            is_write_q  <= 1'b0;
            wdata_q     <= '0;
            read_data_q <= '0;
            addr_err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    idx_q      <= word_d[IW-1:0];
                    in_range_q <= in_range_d;
                    is_write_q <= bus.mem_write;
                    wdata_q    <= bus.write_data;
                    state_q    <= BUSY;
                end
                BUSY: if (cnt_zero) begin
                    state_q    <= DONE;
                    addr_err_q <= !in_range_q;
                    if (is_write_q) begin
                        if (in_range_q) mem_q[idx_q] <= wdata_q;
                    end else begin
                        read_data_q <= in_range_q ? mem_q[idx_q] : '0;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    addr_err_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
    assign bus.read_data = read_data_q;
    assign bus.addr_err  = addr_err_q;
endmodule

// File: tb/tb_stalling_data_memory.sv
// Directed scoreboard bench for stalling_data_memory (LATENCY=3, BASE_ADDR=1024, DEPTH=64).
module tb_stalling_data_memory;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stalling_data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    stalling_data_memory #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .BASE_ADDR(1024), .LATENCY(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic [31:0] lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [64];
    logic [31:0] mdl_rd;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        mdl_rd = '0;
    endtask

    // Drive one access right after a falling edge, hold it until ready, then release.
    task automatic access(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic rd, input logic wr);
        exp_t        e;
        logic [31:0] off, ix;
        logic        inr;
        int          low;
        off = a - 32'd1024;
        ix  = off >> 2;
        inr = (a >= 32'd1024) && (ix < 32'd64);
        if (wr) begin
            if (inr) mdl[ix[5:0]] = d;
        end else begin
            mdl_rd = inr ? mdl[ix[5:0]] : 32'd0;
        end
        e.rd = mdl_rd; e.err = !inr; e.lat = 32'd4;
        sb.push_back(e);

        bus.addr = a; bus.write_data = d; bus.mem_read = rd; bus.mem_write = wr;
        #1;
        low = 0;
        while (!bus.ready && low < 20) begin
            low++;
            @(negedge clk); #1;
        end
        e = sb.pop_front();
        chk({tag, ".lat"},  32'(low),            e.lat);
        chk({tag, ".rd"},   bus.read_data,       e.rd);
        chk({tag, ".err"},  32'(bus.addr_err),   32'(e.err));
        @(negedge clk); #1;
        chk({tag, ".errclr"}, 32'(bus.addr_err), 32'd0);
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    endtask

    initial begin
        bus.addr = '0; bus.write_data = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst.ready", 32'(bus.ready), 32'd1);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst.ready", 32'(bus.ready),   32'd1);
        chk("post_rst.rd",    bus.read_data,    32'd0);
        chk("post_rst.err",   32'(bus.addr_err), 32'd0);

        access("rd1100",     32'd1100, 32'd0,          1'b1, 1'b0);
        access("wr1028",     32'd1028, 32'hDEADBEEF,   1'b0, 1'b1);
        access("rd1028",     32'd1028, 32'd0,          1'b1, 1'b0);
        access("wr1024",     32'd1024, 32'h11,         1'b0, 1'b1);
        access("b2b_rd1024", 32'd1024, 32'd0,          1'b1, 1'b0);
        access("rd1020",     32'd1020, 32'd0,          1'b1, 1'b0);
        access("wr1280",     32'd1280, 32'hFFFF,       1'b0, 1'b1);
        access("rd1024b",    32'd1024, 32'd0,          1'b1, 1'b0);
        access("wr1028b",    32'd1028, 32'h1234_5678,  1'b0, 1'b1);
        access("rd1020b",    32'd1020, 32'd0,          1'b1, 1'b0);

        // Abort a write two cycles into its wait states.
        bus.addr = 32'd1032; bus.write_data = 32'hA5A5; bus.mem_write = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        bus.mem_write = 1'b0;
        #1;
        chk("midrst.ready", 32'(bus.ready),    32'd1);
        chk("midrst.err",   32'(bus.addr_err), 32'd0);
        chk("midrst.rd",    bus.read_data,     32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk); #1;
        chk("after_rst.ready", 32'(bus.ready), 32'd1);

        access("rd1032",   32'd1032, 32'd0,    1'b1, 1'b0);
        access("rd1028c",  32'd1028, 32'd0,    1'b1, 1'b0);
        access("wr1024c",  32'd1024, 32'h11,   1'b0, 1'b1);
        access("rd1024c",  32'd1024, 32'd0,    1'b1, 1'b0);
        access("both1036", 32'd1036, 32'h77,   1'b1, 1'b1);
        access("rd1036",   32'd1036, 32'd0,    1'b1, 1'b0);
        access("rd_last",  32'd1276, 32'd0,    1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
